rgmii_rx: RTL and testbench



---
 rtl/rgmii_pkg.sv | 18 +
 rtl/rgmii_iddr_bank.sv | 29 ++
 rtl/rgmii_rx.sv | 152 +++++++++++++++
 tb/tb_rgmii_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared RGMII speed codes, nibble FSM states and IDDR settings
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    typedef enum logic [1:0] {
        NIB_IDLE = 2'b00,
        NIB_LOW  = 2'b01,
        NIB_HIGH = 2'b10
    } nib_state_t;

    localparam string IDDR_DDR_CLK_EDGE = "SAME_EDGE_PIPELINED";
    localparam logic  IDDR_INIT         = 1'b0;
    localparam string IDDR_SRTYPE       = "SYNC";

endpackage

// File: rtl/rgmii_iddr_bank.sv
// rtl/rgmii_iddr_bank.sv - DDR capture of rxd/rxctl, rise/fall pair on one clk edge
module rgmii_iddr_bank (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rxd,
    input  logic       rxctl,
    output logic [3:0] d_r,
    output logic [3:0] d_f,
    output logic       ctl_r,
    output logic       ctl_f
);

    logic [4:0] rise_s;
    logic [4:0] fall_s;

    always_ff @(posedge clk) rise_s <= {rxctl, rxd};
    always_ff @(negedge clk) fall_s <= {rxctl, rxd};

    // Re-time both halves onto the next rising edge so a pair is presented together
    always_ff @(posedge clk) begin
        if (rst) begin
            {ctl_r, d_r, ctl_f, d_f} <= '0;
        end else begin
            {ctl_r, d_r} <= rise_s;
            {ctl_f, d_f} <= fall_s;
        end
    end

endmodule

// File: rtl/rgmii_rx.sv
// rtl/rgmii_rx.sv - RGMII receive: pair decode, in-band status, mode latch, nibble FSM
module rgmii_rx
    import rgmii_pkg::*;
#(
    parameter bit         USE_INBAND_STATUS = 1'b1,
    parameter logic [1:0] FORCED_SPEED      = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eth_rxctl,
    input  logic [3:0] eth_rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       data_enable,
    output logic       data_error,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex
);

    logic [3:0] iq_dr, iq_df;
    logic       iq_cr, iq_cf;
    logic       iddr_vld, dec_vld;
    logic       dv_d, er_d, dv_last, in_frame, mode_q;
    logic [3:0] dr_d, df_d, low_q;
    logic       er_lat;
    nib_state_t state, state_n;
    logic       dv_rise, active, mode_now, load_low;
    logic [7:0] data_n;
    logic       valid_n, en_n, err_n;
    logic [1:0] speed_code;

    rgmii_iddr_bank u_iddr (
        .clk   (clk),
        .rst   (rst),
        .rxd   (eth_rxd),
        .rxctl (eth_rxctl),
        .d_r   (iq_dr),
        .d_f   (iq_df),
        .ctl_r (iq_cr),
        .ctl_f (iq_cf)
    );

    assign speed_code = USE_INBAND_STATUS ? link_speed : FORCED_SPEED;

    always_ff @(posedge clk) begin
        if (rst) begin
            iddr_vld <= 1'b0;
            dec_vld  <= 1'b0;
            dv_d     <= 1'b0;
            er_d     <= 1'b0;
            dr_d     <= 4'h0;
            df_d     <= 4'h0;
            link_up     <= 1'b0;
            link_speed  <= SPEED_10;
            full_duplex <= 1'b0;
        end else begin
            iddr_vld <= 1'b1;
            dec_vld  <= iddr_vld;
            dv_d     <= iq_cr;
            er_d     <= iq_cr ^ iq_cf;
            dr_d     <= iq_dr;
            df_d     <= iq_df;
            if (iddr_vld && !iq_cr && !iq_cf && (iq_dr == iq_df)) begin
                link_up     <= iq_dr[0];
                link_speed  <= iq_dr[2:1];
                full_duplex <= iq_dr[3];
            end
        end
    end

    // dv_last reads as high while the pipeline refills after reset, so a frame
    // already in progress is ignored until a genuine dv rising edge.
    always_comb begin
        dv_rise  = dec_vld & dv_d & ~dv_last;
        active   = dec_vld & dv_d & (in_frame | dv_rise);
        mode_now = dv_rise ? (speed_code == SPEED_1000) : mode_q;
        state_n  = state;
        load_low = 1'b0;
        data_n   = 8'h00;
        valid_n  = 1'b0;
        en_n     = 1'b0;
        err_n    = 1'b0;
        if (mode_now) begin
            state_n = NIB_IDLE;
            if (active) begin
                data_n  = {df_d, dr_d};
                valid_n = 1'b1;
                en_n    = 1'b1;
                err_n   = er_d;
            end
        end else begin
            case (state)
                NIB_IDLE: if (active) begin
                    load_low = 1'b1;
                    state_n  = NIB_HIGH;
                end
                NIB_HIGH: begin
                    valid_n = 1'b1;
                    en_n    = 1'b1;
                    if (active) begin
                        data_n  = {dr_d, low_q};
                        err_n   = er_lat | er_d;
                        state_n = NIB_LOW;
                    end else begin
                        data_n  = {4'h0, low_q};
                        err_n   = 1'b1;
                        state_n = NIB_IDLE;
                    end
                end
                NIB_LOW: begin
                    if (active) begin
                        load_low = 1'b1;
                        state_n  = NIB_HIGH;
                    end else begin
                        state_n = NIB_IDLE;
                    end
                end
                default: state_n = NIB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NIB_IDLE;
            low_q       <= 4'h0;
            er_lat      <= 1'b0;
            dv_last     <= 1'b1;
            in_frame    <= 1'b0;
            mode_q      <= (FORCED_SPEED == SPEED_1000);
            data        <= 8'h00;
            data_valid  <= 1'b0;
            data_enable <= 1'b0;
            data_error  <= 1'b0;
        end else begin
            state    <= state_n;
            dv_last  <= dec_vld ? dv_d : 1'b1;
            in_frame <= active;
            mode_q   <= mode_now;
            if (load_low) begin
                low_q  <= dr_d;
                er_lat <= er_d;
            end
            data        <= data_n;
            data_valid  <= valid_n;
            data_enable <= en_n;
            data_error  <= err_n;
        end
    end

endmodule

// File: tb/tb_rgmii_rx.sv
// tb/tb_rgmii_rx.sv - directed bench for rgmii_rx
module tb_rgmii_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eth_rxctl = 1'b0;
    logic [3:0] eth_rxd = 4'h0;
    logic [7:0] data;
    logic       data_valid, data_enable, data_error;
    logic       link_up, full_duplex;
    logic [1:0] link_speed;

    rgmii_rx dut (
        .clk         (clk),
        .rst         (rst),
        .eth_rxctl   (eth_rxctl),
        .eth_rxd     (eth_rxd),
        .data        (data),
        .data_valid  (data_valid),
        .data_enable (data_enable),
        .data_error  (data_error),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .full_duplex (full_duplex)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rise_cyc;
    logic [3:0] st = 4'h0;

    logic [7:0] q_data[$];
    logic       q_valid[$];
    logic       q_err[$];
    int         q_cyc[$];

    always @(negedge clk) begin
        if (data_enable) begin
            q_data.push_back(data);
            q_valid.push_back(data_valid);
            q_err.push_back(data_error);
            q_cyc.push_back(cyc);
        end
    end

    logic [7:0] f1 [10] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h0A, 8'h0B};
    logic [7:0] f2 [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rise half is set up before the rising edge, fall half before the falling edge
    task automatic pair(input logic [3:0] dr, input logic cr, input logic [3:0] df, input logic cf);
        @(negedge clk); #2;
        eth_rxd = dr; eth_rxctl = cr;
        @(posedge clk); #2;
        rise_cyc = cyc;
        eth_rxd = df; eth_rxctl = cf;
    endtask

    task automatic byte1000(input logic [7:0] b, input logic e);
        pair(b[3:0], 1'b1, b[7:4], ~e);
    endtask

    task automatic nib(input logic [3:0] n);
        pair(n, 1'b1, n, 1'b1);
    endtask

    task automatic idle(input int k);
        repeat (k) pair(st, 1'b0, st, 1'b0);
    endtask

    task automatic clearq();
        q_data.delete(); q_valid.delete(); q_err.delete(); q_cyc.delete();
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_data"}, data, 8'h00);
        chk({tag, "_valid"}, data_valid, 1'b0);
        chk({tag, "_enable"}, data_enable, 1'b0);
        chk({tag, "_error"}, data_error, 1'b0);
        chk({tag, "_link_up"}, link_up, 1'b0);
        chk({tag, "_link_speed"}, link_speed, 2'b00);
        chk({tag, "_duplex"}, full_duplex, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, h1, h3, hc;

        repeat (3) pair(4'h0, 1'b0, 4'h0, 1'b0);
        chk_outputs_reset("reset");
        rst = 1'b0;

        // Non-qualifying pairs (d_r != d_f) leave status alone
        repeat (4) pair(4'b1101, 1'b0, 4'b0000, 1'b0);
        chk("noq_link_up", link_up, 1'b0);
        chk("noq_speed", link_speed, 2'b00);
        chk("noq_duplex", full_duplex, 1'b0);

        st = 4'b1101;
        pair(st, 1'b0, 4'b0000, 1'b0);
        pair(st, 1'b0, st, 1'b0);
        pair(st, 1'b0, 4'b0000, 1'b0);
        chk("status_early", link_up, 1'b0);
        pair(st, 1'b0, 4'b0000, 1'b0);
        chk("status_link_up", link_up, 1'b1);
        chk("status_speed", link_speed, 2'b10);
        chk("status_duplex", full_duplex, 1'b1);
        idle(2);

        clearq();
        t0 = 0;
        for (int i = 0; i < 10; i++) begin
            byte1000(f1[i], 1'b0);
            if (i == 0) t0 = rise_cyc;
        end
        idle(6);
        chk("g_count", q_data.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("g_data%0d", i), q_data[i], f1[i]);
            chk($sformatf("g_valid%0d", i), q_valid[i], 1'b1);
            chk($sformatf("g_err%0d", i), q_err[i], 1'b0);
            chk($sformatf("g_cyc%0d", i), q_cyc[i], t0 + 3 + i);
        end

        clearq();
        for (int i = 0; i < 5; i++) byte1000(f2[i], (i == 3));
        idle(6);
        chk("er_count", q_data.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("er_data%0d", i), q_data[i], f2[i]);
            chk($sformatf("er_err%0d", i), q_err[i], (i == 3));
        end

        // False carrier with all-zero data would clear link_up if it were taken as status
        clearq();
        repeat (4) pair(4'h0, 1'b0, 4'h0, 1'b1);
        chk("fc_link_up", link_up, 1'b1);
        chk("fc_speed", link_speed, 2'b10);
        idle(4);
        chk("fc_count", q_data.size(), 0);

        st = 4'b1011;
        idle(4);
        chk("s100_link_up", link_up, 1'b1);
        chk("s100_speed", link_speed, 2'b01);
        chk("s100_duplex", full_duplex, 1'b1);

        clearq();
        nib(4'h5);
        nib(4'h5); h1 = rise_cyc;
        nib(4'hD);
        nib(4'h5); h3 = rise_cyc;
        idle(6);
        chk("n_count", q_data.size(), 2);
        chk("n_data0", q_data[0], 8'h55);
        chk("n_data1", q_data[1], 8'h5D);
        chk("n_valid0", q_valid[0], 1'b1);
        chk("n_err0", q_err[0], 1'b0);
        chk("n_err1", q_err[1], 1'b0);
        chk("n_cyc0", q_cyc[0], h1 + 3);
        chk("n_cyc1", q_cyc[1], h3 + 3);
        chk("n_gap", (q_cyc[1] - q_cyc[0]) >= 2, 1'b1);

        clearq();
        nib(4'hA);
        nib(4'hB);
        nib(4'hC); hc = rise_cyc;
        idle(6);
        chk("odd_count", q_data.size(), 2);
        chk("odd_data0", q_data[0], 8'hBA);
        chk("odd_err0", q_err[0], 1'b0);
        chk("odd_data1", q_data[1], 8'h0C);
        chk("odd_valid1", q_valid[1], 1'b1);
        chk("odd_err1", q_err[1], 1'b1);
        chk("odd_cyc1", q_cyc[1], hc + 4);

        clearq();
        nib(4'h1);
        nib(4'h2);
        nib(4'h3);
        rst = 1'b1;
        nib(4'h4);
        chk_outputs_reset("midrst");
        rst = 1'b0;
        nib(4'h5);
        nib(4'h6);
        idle(6);
        chk("midrst_count", q_data.size(), 0);
        nib(4'h7);
        nib(4'h8);
        idle(6);
        chk("resume_count", q_data.size(), 1);
        chk("resume_data", q_data[0], 8'h87);
        chk("resume_valid", q_valid[0], 1'b1);
        chk("resume_err", q_err[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
